// File: rtl/gg_div_pkg.sv
// gg_div_pkg -- shared constants for the gg_div8 restoring divider. Rev 1.0
`default_nettype none

package gg_div_pkg;

  localparam int GG_DIV_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [GG_DIV_W-1:0] DZ_QUOT = '1;

endpackage

`default_nettype wire

// File: rtl/gg_sub9.sv
// gg_sub9 -- combinational (N)-bit subtract-with-borrow X + ~Y + 1; o_co=1 means no borrow. Rev 1.0
`default_nettype none

module gg_sub9 #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_diff,
  output logic         o_co
);

  assign {o_co, o_diff} = {1'b0, i_x} + {1'b0, ~i_y} + {{N{1'b0}}, 1'b1};

endmodule

`default_nettype wire

// File: rtl/gg_div8.sv
// gg_div8 -- sequential unsigned restoring divider, one quotient bit per clock. Rev 1.0
// Define GG_DIV8_SPECIFY_EN to add unit-delay clock-to-output specify paths.
`default_nettype none

module gg_div8
  import gg_div_pkg::*;
#(
  parameter int W = GG_DIV_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         DONE,
  output logic         BUSY,
  output logic         DZ
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_last = CW'(W - 1);
  // DZ_QUOT is all ones; replicate to the configured width
  localparam logic [W-1:0]  c_dz_q = {W{&DZ_QUOT}};

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_dvd;
  logic [W-1:0]  r_dvs;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic          r_bz;

  logic [W:0]    w_rem_sh;
  logic [W:0]    w_diff;
  logic          w_co;
  logic [W:0]    w_rem_nx;
  logic [W-1:0]  w_quo_nx;
  logic          w_last;
  logic          w_unused_msb;

  assign w_rem_sh = {r_rem[W-1:0], r_dvd[W-1]};

  gg_sub9 #(.N(W + 1)) u_sub (
    .i_x    (w_rem_sh),
    .i_y    ({1'b0, r_dvs}),
    .o_diff (w_diff),
    .o_co   (w_co)
  );

  assign w_rem_nx = w_co ? w_diff : w_rem_sh;
  assign w_quo_nx = {r_quo[W-2:0], w_co};
  assign w_last   = (r_cnt == c_last);
  // A partial remainder is always below the divisor, so its top bit stays zero
  assign w_unused_msb = r_rem[W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_bz    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      DZ      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_dvd   <= A;
            r_dvs   <= B;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_bz    <= (B == '0);
            BUSY    <= (B != '0);
            r_state <= (B != '0) ? S_RUN : S_FIN;
          end
        end
        S_RUN: begin
          r_dvd <= {r_dvd[W-2:0], 1'b0};
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_FIN;
            BUSY    <= 1'b0;
            Q       <= w_quo_nx;
            R       <= w_rem_nx[W-1:0];
            DZ      <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        S_FIN: begin
          // Divide-by-zero results are published as FIN is left
          r_state <= S_IDLE;
          if (r_bz) begin
            Q    <= c_dz_q;
            R    <= r_dvd;
            DZ   <= 1'b1;
            DONE <= 1'b1;
            r_bz <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GG_DIV8_SPECIFY_EN
  specify
    (CLK *> Q)    = 1;
    (CLK *> R)    = 1;
    (CLK *> DONE) = 1;
    (CLK *> BUSY) = 1;
    (CLK *> DZ)   = 1;
  endspecify
`else
  // Zero-delay outputs.
`endif

endmodule

`default_nettype wire

// File: tb/tb_gg_div8.sv
// tb_gg_div8 -- scoreboard bench for the gg_div8 restoring divider. Rev 1.0
`default_nettype none

module tb_gg_div8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       DONE;
  logic       BUSY;
  logic       DZ;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } res_t;

  res_t sb[$];
  res_t last = '0;
  int   n_total = 0;
  int   n_bad   = 0;

  gg_div8 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .DONE  (DONE),
    .BUSY  (BUSY),
    .DZ    (DZ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One division; optionally pulses a foreign START after inject_at edges of the run.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input int inject_at);
    res_t e;
    int   lat;
    bit   seen;
    @(negedge CLK);
    A = a;
    B = b;
    START = 1'b1;
    e.q  = (b == 8'd0) ? 8'hFF : a / b;
    e.r  = (b == 8'd0) ? a : a % b;
    e.dz = (b == 8'd0);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    chk("busy_at_k", 32'(BUSY), 32'(b != 8'd0));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (inject_at > 0 && lat == inject_at) begin
        START = 1'b1;
        A = 8'd1;
        B = 8'd1;
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
      lat++;
      if (DONE) begin
        seen = 1'b1;
      end else begin
        chk("q_hold", 32'(Q), 32'(last.q));
        chk("r_hold", 32'(R), 32'(last.r));
        chk("busy_run", 32'(BUSY), 32'(b != 8'd0));
      end
    end
    chk("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd8);
    e = sb.pop_front();
    if (seen) begin
      chk("quotient", 32'(Q), 32'(e.q));
      chk("remainder", 32'(R), 32'(e.r));
      chk("dz", 32'(DZ), 32'(e.dz));
      chk("busy_done", 32'(BUSY), 32'd0);
    end
    last = e;
    @(posedge CLK);
    #1;
    chk("done_pulse", 32'(DONE), 32'd0);
    chk("q_after", 32'(Q), 32'(last.q));
    chk("busy_after", 32'(BUSY), 32'd0);
  endtask

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_dz", 32'(DZ), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run(8'd200, 8'd7, 0);
    run(8'd255, 8'd1, 0);
    run(8'd5, 8'd9, 0);
    run(8'd0, 8'd3, 0);
    run(8'd17, 8'd0, 0);
    run(8'd17, 8'd3, 0);
    run(8'd100, 8'd10, 3);

    // Asynchronous reset between edges in the middle of a run
    @(negedge CLK);
    A = 8'd200;
    B = 8'd7;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_q", 32'(Q), 32'd0);
    chk("arst_r", 32'(R), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_dz", 32'(DZ), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    last = '0;
    run(8'd9, 8'd2, 0);

    run(8'd254, 8'd255, 0);
    run(8'd255, 8'd255, 0);
    run(8'd128, 8'd128, 0);
    run(8'd0, 8'd0, 0);
    run(8'd255, 8'd2, 0);
    for (int i = 0; i < 1500; i++) begin
      run(8'($urandom), (i % 16 == 0) ? 8'd0 : 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
